// File: rtl/packet_queue_pkg.sv
// Shared types for the committed-packet queue: reader/writer state
// encodings, size-width constants and the size-to-beats helper.
package packet_queue_pkg;

    // Packet size limits (bytes) shared by writer and reader sides.
    localparam int MTU_SIZE         = 9216;
    localparam int MTU_SIZE_W       = 14;
    // Width of a byte offset within one 512-bit NoC element.
    localparam int NOC_DATA_BYTES_W = 6;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WRITE,
        WR_DROP
    } wr_state_e;

    typedef struct packed {
        logic [MTU_SIZE_W:0]         beats;
        logic [NOC_DATA_BYTES_W-1:0] pad;
    } beat_calc_t;

    // Beat count is a ceiling divide; the sum carries one extra bit so
    // a size of MTU_SIZE cannot wrap. Pad is the unused tail of the
    // last element, zero when the size is an exact multiple.
    function automatic beat_calc_t calc_beats(
        input logic [MTU_SIZE_W-1:0] size,
        input int unsigned           data_bytes
    );
        beat_calc_t          r;
        logic [MTU_SIZE_W:0] sum;
        sum     = {1'b0, size} + (MTU_SIZE_W+1)'(data_bytes - 1);
        r.beats = sum >> $clog2(data_bytes);
        r.pad   = NOC_DATA_BYTES_W'((data_bytes - 32'(size)) &
                                    (data_bytes - 1));
        return r;
    endfunction

endpackage

// File: rtl/packet_queue_drain_ctrl.sv
// Read-side drain controller: pops one size entry per packet, then
// streams ceil(size/bytes) elements downstream with SOF/EOF/pad framing.
// Ports: clk/rst; pkt_size_queue_* (size pop, show-ahead);
// data_* (element pop, show-ahead); out_* (valid/ready beat stream);
// err_zero_size (pulse when a zero-length entry is discarded).
module packet_queue_drain_ctrl
    import packet_queue_pkg::*;
#(
    parameter  int data_width_p     = 512,
    localparam int data_bytes_p     = data_width_p / 8,
    localparam int data_pad_width_p = $clog2(data_width_p / 8)
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        pkt_size_queue_rd_req,
    input  logic                        pkt_size_queue_empty,
    input  logic [MTU_SIZE_W-1:0]       pkt_size_queue_rd_data,
    output logic                        data_rd_req,
    input  logic                        data_empty,
    input  logic [data_width_p-1:0]     data_rd_data,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [data_width_p-1:0]     out_data,
    output logic                        out_start_frame,
    output logic                        out_end_frame,
    output logic [data_pad_width_p-1:0] out_padbytes,
    output logic [MTU_SIZE_W-1:0]       out_pkt_size,
    output logic                        err_zero_size
);

    rd_state_e                   r_state;
    rd_state_e                   w_next_state;
    logic [MTU_SIZE_W:0]         r_beats_rem;
    logic                        r_first;
    logic [data_pad_width_p-1:0] r_pad;
    logic [MTU_SIZE_W-1:0]       r_size;

    beat_calc_t                  w_calc;
    logic                        w_size_pop;
    logic                        w_size_zero;
    logic                        w_hs;
    logic                        w_end;

    assign w_calc      = calc_beats(pkt_size_queue_rd_data, data_bytes_p);
    assign w_size_zero = (pkt_size_queue_rd_data == '0);
    assign w_size_pop  = ~rst & (r_state == RD_IDLE) & ~pkt_size_queue_empty;
    assign w_end       = (r_beats_rem == (MTU_SIZE_W+1)'(1));
    // Gated by rst so no pop or beat leaks out during the reset cycle.
    assign w_hs        = ~rst & (r_state == RD_STREAM) & ~data_empty & out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            RD_IDLE: begin
                if (w_size_pop && !w_size_zero) begin
                    w_next_state = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (w_hs && w_end) begin
                    w_next_state = RD_IDLE;
                end
            end
            default: w_next_state = RD_IDLE;
        endcase
    end

    always_comb begin
        pkt_size_queue_rd_req = 1'b0;
        err_zero_size         = 1'b0;
        data_rd_req           = 1'b0;
        out_val               = 1'b0;
        out_start_frame       = 1'b0;
        out_end_frame         = 1'b0;
        out_padbytes          = '0;
        unique case (r_state)
            RD_IDLE: begin
                pkt_size_queue_rd_req = w_size_pop;
                err_zero_size         = w_size_pop & w_size_zero;
            end
            RD_STREAM: begin
                out_val         = ~rst & ~data_empty;
                out_start_frame = r_first;
                out_end_frame   = w_end;
                out_padbytes    = w_end ? r_pad : '0;
                data_rd_req     = w_hs;
            end
            default: ;
        endcase
    end

    assign out_data     = data_rd_data;
    assign out_pkt_size = r_size;

    // Size arithmetic is registered on the pop so the stream state
    // starts from stable beat/pad values on its first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beats_rem <= '0;
            r_first     <= 1'b0;
            r_pad       <= '0;
            r_size      <= '0;
        end else if (w_size_pop) begin
            r_size      <= pkt_size_queue_rd_data;
            r_beats_rem <= w_calc.beats;
            r_pad       <= w_calc.pad[data_pad_width_p-1:0];
            r_first     <= ~w_size_zero;
        end else if (w_hs) begin
            r_beats_rem <= r_beats_rem - (MTU_SIZE_W+1)'(1);
            r_first     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packet_queue_drain_ctrl.sv
// Randomized bench for packet_queue_drain_ctrl with a queue-based
// model of the size/data queues and the expected framed beat stream.
module tb_packet_queue_drain_ctrl;
    import packet_queue_pkg::*;

    localparam int DW = 512;
    localparam int DB = DW / 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  pkt_size_queue_rd_req;
    logic                  pkt_size_queue_empty = 1'b1;
    logic [MTU_SIZE_W-1:0] pkt_size_queue_rd_data = '0;
    logic                  data_rd_req;
    logic                  data_empty = 1'b1;
    logic [DW-1:0]         data_rd_data = '0;
    logic                  out_val;
    logic                  out_rdy = 1'b0;
    logic [DW-1:0]         out_data;
    logic                  out_start_frame;
    logic                  out_end_frame;
    logic [5:0]            out_padbytes;
    logic [MTU_SIZE_W-1:0] out_pkt_size;
    logic                  err_zero_size;

    packet_queue_drain_ctrl #(.data_width_p(DW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .pkt_size_queue_rd_req  (pkt_size_queue_rd_req),
        .pkt_size_queue_empty   (pkt_size_queue_empty),
        .pkt_size_queue_rd_data (pkt_size_queue_rd_data),
        .data_rd_req            (data_rd_req),
        .data_empty             (data_empty),
        .data_rd_data           (data_rd_data),
        .out_val                (out_val),
        .out_rdy                (out_rdy),
        .out_data               (out_data),
        .out_start_frame        (out_start_frame),
        .out_end_frame          (out_end_frame),
        .out_padbytes           (out_padbytes),
        .out_pkt_size           (out_pkt_size),
        .err_zero_size          (err_zero_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            sof;
        bit            eof;
        int            pad;
        int            size;
    } beat_t;

    int            sq[$];
    logic [DW-1:0] dq[$];
    beat_t         expq[$];
    int            hs_log[$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  rdy_mode = 0;
    int  pat = 0;
    bit  in_pkt = 0;
    bit  prev_stall = 0;
    logic [DW-1:0] prev_data;
    bit  prev_sof, prev_eof;
    int  prev_pad;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_elem();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_pkt(input int s);
        int nb;
        beat_t b;
        sq.push_back(s);
        nb = (s + DB - 1) / DB;
        for (int i = 0; i < nb; i++) begin
            b.d    = rand_elem();
            b.sof  = (i == 0);
            b.eof  = (i == nb - 1);
            b.pad  = b.eof ? nb * DB - s : 0;
            b.size = s;
            dq.push_back(b.d);
            expq.push_back(b);
        end
    endtask

    task automatic step(input bit rst_v);
        bit e_rd, e_val, hs;
        int s;
        beat_t b;
        @(negedge clk);
        cyc++;
        rst = rst_v;
        case (rdy_mode)
            0: out_rdy = 1'b1;
            1: begin out_rdy = (pat % 3 == 0); pat++; end
            default: out_rdy = ($urandom_range(0, 9) < 7);
        endcase
        pkt_size_queue_empty   = (sq.size() == 0);
        pkt_size_queue_rd_data = pkt_size_queue_empty ? '0 : MTU_SIZE_W'(sq[0]);
        data_empty             = (dq.size() == 0);
        data_rd_data           = data_empty ? '0 : dq[0];
        #1;
        if (rst_v) begin
            chk("rst_size_rd", pkt_size_queue_rd_req, 0);
            chk("rst_data_rd", data_rd_req, 0);
            chk("rst_val", out_val, 0);
            chk("rst_err", err_zero_size, 0);
            sq.delete(); dq.delete(); expq.delete();
            in_pkt = 0;
            prev_stall = 0;
            return;
        end
        e_rd  = !in_pkt && !pkt_size_queue_empty;
        e_val = in_pkt && !data_empty;
        chk("size_rd", pkt_size_queue_rd_req, e_rd);
        chk("err_zero", err_zero_size, e_rd && pkt_size_queue_rd_data == 0);
        chk("out_val", out_val, e_val);
        hs = out_val && out_rdy;
        chk("data_rd", data_rd_req, hs);
        if (prev_stall) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_sof", out_start_frame, prev_sof);
            chk("hold_eof", out_end_frame, prev_eof);
            chk("hold_pad", out_padbytes, prev_pad);
        end
        if (out_val && expq.size() > 0) begin
            b = expq[0];
            chk("data", out_data, b.d);
            chk("sof", out_start_frame, b.sof);
            chk("eof", out_end_frame, b.eof);
            chk("pad", out_padbytes, b.pad);
            chk("pkt_size", out_pkt_size, b.size);
        end
        prev_stall = out_val && !out_rdy;
        prev_data  = out_data;
        prev_sof   = out_start_frame;
        prev_eof   = out_end_frame;
        prev_pad   = int'(out_padbytes);
        if (hs) begin
            hs_log.push_back(cyc);
            b = expq.pop_front();
            void'(dq.pop_front());
            if (b.eof) in_pkt = 0;
        end
        if (pkt_size_queue_rd_req) begin
            s = sq.pop_front();
            if (s != 0) in_pkt = 1;
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((sq.size() != 0 || expq.size() != 0 || in_pkt) && n < max) begin
            step(0);
            n++;
        end
        chk("drain_left", expq.size(), 0);
    endtask

    task automatic chk_offsets(input int base, input int o[$]);
        chk("hs_count", hs_log.size(), o.size());
        for (int i = 0; i < o.size() && i < hs_log.size(); i++)
            chk("hs_cycle", hs_log[i] - base, o[i]);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 3; i++) step(1);
        step(0);
        chk("idle_val", out_val, 0);

        // single-beat packet: pop at +0, beat at +1
        rdy_mode = 0;
        push_pkt(64);
        hs_log.delete();
        base = cyc + 1;
        for (int i = 0; i < 3; i++) step(0);
        chk_offsets(base, '{1});

        push_pkt(130);
        drain(20);

        rdy_mode = 1; pat = 0;
        push_pkt(1500);
        drain(200);
        rdy_mode = 0;

        // back-to-back packets: one bubble between them
        push_pkt(64);
        push_pkt(128);
        hs_log.delete();
        base = cyc + 1;
        for (int i = 0; i < 6; i++) step(0);
        chk_offsets(base, '{1, 3, 4});

        push_pkt(0);
        push_pkt(65);
        drain(20);

        push_pkt(MTU_SIZE);
        drain(400);

        // reset while beat 2 of a 5-beat packet is presented
        push_pkt(300);
        while (expq.size() > 3 && cyc < 5000) step(0);
        chk("pre_rst_left", expq.size(), 3);
        step(1);
        step(0);
        chk("post_rst_val", out_val, 0);
        push_pkt(200);
        drain(20);

        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if (sq.size() < 3 && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 9))
                    0: push_pkt(0);
                    1: push_pkt(MTU_SIZE);
                    2: push_pkt($urandom_range(1, 64));
                    default: push_pkt($urandom_range(1, 1600));
                endcase
            end
            step(0);
        end
        drain(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
